mem_access_unit: RTL and testbench

MEM-stage load/store unit that sits directly downstream of the pipelined CPU's EX/MEM register, in place of the single-cycle data memory port. It connects the CPU's MemRead/MemWrite/address/write-data signals to a variable-latency backing memory over a req/ack handshake. A small posted write buffer retires stores without stalling, and loads that hit the buffer are forwarded. The unit raises `stall_o` to freeze the pipeline while a load miss is outstanding.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store unit with a posted write buffer,
//                   store-to-load forwarding and a req/ack backing-memory port.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int WB_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_WB_FULL = CW'(WB_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [29:0]   wb_addr_q [WB_DEPTH];
  logic [29:0]   wb_addr_d [WB_DEPTH];
  logic [31:0]   wb_data_q [WB_DEPTH];
  logic [31:0]   wb_data_d [WB_DEPTH];
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          misalign;
  logic          is_store;
  logic          is_load;
  logic          wb_full;
  logic          wb_empty;
  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] hit_idx;
  logic          load_miss;
  logic          push;
  logic          pop;

  always_comb begin
    misalign = (MemRead_i | MemWrite_i) && (addr_i[1:0] != 2'b00);
    is_store = MemWrite_i && !misalign;
    is_load  = MemRead_i && !MemWrite_i && !misalign;
    wb_full  = (count_q == C_WB_FULL);
    wb_empty = (count_q == '0);
  end

  // Walk the valid entries oldest to newest so the newest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      hit_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_addr_q[hit_idx] == addr_i[31:2])) begin
        hit      = 1'b1;
        hit_data = wb_data_q[hit_idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    push        = is_store && !wb_full;
    // The load held in RD_DONE has already been served from rdata_q.
    load_miss   = is_load && !hit && (state_q != RD_DONE);

    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d    = RD_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_i[31:2], 2'b00};
        end else if (!wb_empty) begin
          state_d     = WR_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {wb_addr_q[head_q], 2'b00};
          mem_wdata_d = wb_data_q[head_q];
        end
      end
      WR_BUSY: begin
        if (mem_ack_i) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_BUSY: begin
        if (mem_ack_i) begin
          rdata_d   = mem_rdata_i;
          mem_req_d = 1'b0;
          state_d   = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      wb_addr_d[tail_q] = addr_i[31:2];
      wb_data_d[tail_q] = data_i;
      tail_d            = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_comb begin
    misalign_o = misalign;
    stall_o    = (is_store && wb_full) || load_miss || (state_q == RD_BUSY);
    if (is_load && (state_q == RD_DONE)) begin
      data_o = rdata_q;
    end else if (is_load && hit) begin
      data_o = hit_data;
    end else begin
      data_o = '0;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed + random bench against an architectural
//                      memory model (loads return the newest store value).
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data_o;
  logic        stall_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(.WB_DEPTH(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int ack_wait = 0;

  logic [31:0] arch_mem [logic [29:0]];
  logic [31:0] bk_mem   [logic [29:0]];
  logic [29:0] wq_addr  [$];
  logic [31:0] wq_data  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w[13:0], w[29:12]} ^ 32'hA5C3_0F17;
  endfunction

  function automatic logic [31:0] arch_read(input logic [29:0] w);
    return arch_mem.exists(w) ? arch_mem[w] : dflt(w);
  endfunction

  function automatic logic [31:0] bk_read(input logic [29:0] w);
    return bk_mem.exists(w) ? bk_mem[w] : dflt(w);
  endfunction

  // Backing memory: acks after ack_wait idle request cycles.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req_o) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we_o ? 32'h0 : bk_read(mem_addr_o[31:2]);
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Completed writes must match accepted stores in order; req must drop after each handshake.
  initial begin
    logic prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("req_gap", {31'b0, mem_req_o}, 32'd0);
        prev_hs = mem_req_o && mem_ack;
        if (mem_req_o && mem_ack) begin
          chk("mem_addr_align", {30'b0, mem_addr_o[1:0]}, 32'd0);
          if (mem_we_o) begin
            if (wq_addr.size() == 0) begin
              chk("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
              chk("wr_addr", mem_addr_o, {wq_addr[0], 2'b00});
              chk("wr_data", mem_wdata_o, wq_data[0]);
              bk_mem[mem_addr_o[31:2]] = mem_wdata_o;
              void'(wq_addr.pop_front());
              void'(wq_data.pop_front());
            end
          end else begin
            n_reads++;
          end
        end
      end
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, output int stalls);
    logic mis;
    stalls    = 0;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    mis       = (rd | wr) && (a[1:0] != 2'b00);
    @(negedge clk);
    while (stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall_bound", {31'b0, stall_o}, 32'd0);
    chk("misalign", {31'b0, misalign_o}, {31'b0, mis});
    if (mis) begin
      chk("mis_data", data_o, 32'd0);
      chk("mis_nostall", stalls, 0);
    end else if (wr) begin
      wq_addr.push_back(a[31:2]);
      wq_data.push_back(d);
      arch_mem[a[31:2]] = d;
    end else if (rd) begin
      chk("load_data", data_o, arch_read(a[31:2]));
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wq_addr.size() != 0 || mem_req_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'b0, (wq_addr.size() == 0 && !mem_req_o)}, 32'd1);
  endtask

  task automatic wait_req(input logic we, input string tag);
    int n;
    n = 0;
    while (!(mem_req_o && mem_we_o == we) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'b0, mem_req_o}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'b0, mem_req_o},  32'd0);
    chk({tag, "_we"},    {31'b0, mem_we_o},   32'd0);
    chk({tag, "_addr"},  mem_addr_o,          32'd0);
    chk({tag, "_wdata"}, mem_wdata_o,         32'd0);
    chk({tag, "_data"},  data_o,              32'd0);
    chk({tag, "_stall"}, {31'b0, stall_o},    32'd0);
    chk({tag, "_mis"},   {31'b0, misalign_o}, 32'd0);
  endtask

  initial begin
    int s0, s1, s2, rb;
    int kind;
    logic [31:0] ra;

    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    rst       = 1'b0;
    #2 rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // single store, immediate ack
    ack_wait = 0;
    op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, s0);
    chk("st1_stall", s0, 0);
    drain("st1_drain");

    // three back-to-back stores into a two-entry buffer with slow acks
    ack_wait = 5;
    op(1'b0, 1'b1, 32'h20, 32'h0000_2020, s0);
    op(1'b0, 1'b1, 32'h24, 32'h0000_2424, s1);
    op(1'b0, 1'b1, 32'h28, 32'h0000_2828, s2);
    chk("st3_s0", s0, 0);
    chk("st3_s1", s1, 0);
    chk("st3_s2_stalled", {31'b0, (s2 > 0)}, 32'd1);
    drain("st3_drain");

    // forwarding from the newest matching entry
    ack_wait = 4;
    rb = n_reads;
    op(1'b0, 1'b1, 32'h30, 32'h1111_1111, s0);
    op(1'b0, 1'b1, 32'h30, 32'h2222_2222, s0);
    op(1'b1, 1'b0, 32'h30, 32'h0, s1);
    chk("fwd_nostall", s1, 0);
    chk("fwd_value", arch_read(30'h30 >> 2), 32'h2222_2222);
    drain("fwd_drain");
    chk("fwd_noread", n_reads, rb);

    // load miss with three ack-wait cycles
    ack_wait = 3;
    bk_mem[30'h10]   = 32'hCAFE_F00D;
    arch_mem[30'h10] = 32'hCAFE_F00D;
    rb = n_reads;
    op(1'b1, 1'b0, 32'h40, 32'h0, s0);
    chk("miss_stalls", s0, 5);
    chk("miss_reads", n_reads, rb + 1);

    // load miss while a buffered write is in flight
    ack_wait = 3;
    op(1'b0, 1'b1, 32'h50, 32'h5555_AAAA, s0);
    wait_req(1'b1, "wr_busy_seen");
    rb = n_reads;
    op(1'b1, 1'b0, 32'h60, 32'h0, s1);
    chk("wrrd_stalls", s1, 9);
    chk("wrrd_wr_first", wq_addr.size(), 0);
    chk("wrrd_reads", n_reads, rb + 1);

    // misaligned load
    drain("pre_mis_drain");
    op(1'b1, 1'b0, 32'h42, 32'h0, s0);
    chk("mis_noreq", {31'b0, mem_req_o}, 32'd0);

    // random mixed traffic on a small address window
    for (int i = 0; i < 300; i++) begin
      if ((i % 25) == 0) ack_wait = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      ra   = 32'h100 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if (kind < 4) begin
        op(1'b0, 1'b1, ra, $urandom, s0);
      end else if (kind < 8) begin
        op(1'b1, kind[0], ra, $urandom, s0);
      end else if (kind == 8) begin
        op(1'($urandom_range(0, 1)), 1'b1, ra | 32'h1, $urandom, s0);
      end else begin
        @(negedge clk);
        chk("idle_stall", {31'b0, stall_o}, 32'd0);
        chk("idle_mis", {31'b0, misalign_o}, 32'd0);
        @(posedge clk);
        #1;
      end
    end
    drain("rand_drain");

    // asynchronous reset while a read is outstanding
    ack_wait  = 20;
    mem_read  = 1'b1;
    addr      = 32'h80;
    wait_req(1'b0, "rd_busy_seen");
    #2;
    rst       = 1'b1;
    mem_read  = 1'b0;
    addr      = '0;
    #1;
    chk_reset("async_rst");
    wq_addr.delete();
    wq_data.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("held_rst");
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
